// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor
// Qualifies a PLL lock signal, measures the PLL output frequency in the
// reference clock domain over a fixed gate window, and releases a downstream
// reset only while lock is stable and the measured edge count is in range.
// Optional feature macro: PLL_CLK_MONITOR_AUTO_RESET_EN. When defined, a
// frequency fault pulses pll_reset for PLLRST_CYC cycles and then restarts
// lock qualification. When undefined, FAULT is left only on rst or lock loss.
module pll_clk_monitor #(
    parameter int SETTLE_CYC = 1024,
    parameter int GATE_CYC   = 2700,
    parameter int EXP_MIN    = 590,
    parameter int EXP_MAX    = 610,
    parameter int CNT_W      = 16,
    parameter int PLLRST_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             pll_clk_in,
    output logic             rst_out,
    output logic             locked_ok,
    output logic             fault,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid,
    output logic             pll_reset
);

    // The settle wait and the PLL reset pulse never overlap, so one counter
    // sized for the longer of the two serves both.
    localparam int AUX_MAX = (SETTLE_CYC > PLLRST_CYC) ? SETTLE_CYC : PLLRST_CYC;
    localparam int AUX_W   = $clog2(AUX_MAX + 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_MEASURE,
        ST_RUN,
        ST_FAULT
    } state_t;

    // Synchroniser stages
    logic r_lock_meta;
    logic r_lock_s;
    logic r_pclk_meta;
    logic r_pclk_s;
    logic r_pclk_d;

    // Control state and counters
    state_t           r_state;
    logic [AUX_W-1:0] r_aux_cnt;
    logic [CNT_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;

    // Registered outputs
    logic             r_rst_out;
    logic             r_locked_ok;
    logic             r_fault;
    logic [CNT_W-1:0] r_freq_cnt;
    logic             r_freq_valid;

    // Combinational helpers
    logic             w_edge;
    logic             w_gate_last;
    logic [CNT_W-1:0] w_edge_total;
    logic             w_in_range;

    assign w_edge       = r_pclk_s & ~r_pclk_d;
    assign w_gate_last  = (r_gate_cnt == CNT_W'(GATE_CYC - 1));
    // Count including an edge seen this cycle; sticks at all-ones instead of wrapping.
    assign w_edge_total = (&r_edge_cnt) ? r_edge_cnt : (r_edge_cnt + CNT_W'(w_edge));
    assign w_in_range   = (w_edge_total >= CNT_W'(EXP_MIN)) &&
                          (w_edge_total <= CNT_W'(EXP_MAX));

    // Bring lock and the measured clock into the reference domain; the third
    // clock-path flop gives the previous sample for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_pclk_meta <= 1'b0;
            r_pclk_s    <= 1'b0;
            r_pclk_d    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_pclk_meta <= pll_clk_in;
            r_pclk_s    <= r_pclk_meta;
            r_pclk_d    <= r_pclk_s;
        end
    end

`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
    logic r_pll_reset;
    assign pll_reset = r_pll_reset;
`else
    assign pll_reset = 1'b0;
`endif

    // Qualification FSM with gate/edge counters and registered outputs.
    // Lock loss is tested first in every active state so it wins over a
    // simultaneous window close (no freq_valid in that case).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_WAIT_LOCK;
            r_aux_cnt    <= '0;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_rst_out    <= 1'b1;
            r_locked_ok  <= 1'b0;
            r_fault      <= 1'b0;
            r_freq_cnt   <= '0;
            r_freq_valid <= 1'b0;
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
            r_pll_reset  <= 1'b0;
`endif
        end else begin
            r_freq_valid <= 1'b0;
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_rst_out   <= 1'b1;
                    r_locked_ok <= 1'b0;
`ifndef PLL_CLK_MONITOR_AUTO_RESET_EN
                    r_fault     <= 1'b0;
`endif
                    if (r_lock_s) begin
                        r_state   <= ST_SETTLE;
                        r_aux_cnt <= '0;
                    end
                end

                ST_SETTLE: begin
                    r_rst_out <= 1'b1;
                    if (!r_lock_s) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_aux_cnt <= '0;
                    end else if (r_aux_cnt == AUX_W'(SETTLE_CYC - 1)) begin
                        r_state    <= ST_MEASURE;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_aux_cnt <= r_aux_cnt + AUX_W'(1);
                    end
                end

                ST_MEASURE: begin
                    r_rst_out <= 1'b1;
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (w_gate_last) begin
                        r_freq_cnt   <= w_edge_total;
                        r_freq_valid <= 1'b1;
                        r_gate_cnt   <= '0;
                        r_edge_cnt   <= '0;
                        if (w_in_range) begin
                            r_state <= ST_RUN;
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
                            r_fault <= 1'b0;
`endif
                        end else begin
                            r_state     <= ST_FAULT;
                            r_fault     <= 1'b1;
                            r_locked_ok <= 1'b0;
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
                            r_pll_reset <= 1'b1;
                            r_aux_cnt   <= '0;
`endif
                        end
                    end else begin
                        r_gate_cnt <= r_gate_cnt + CNT_W'(1);
                        r_edge_cnt <= w_edge_total;
                    end
                end

                ST_RUN: begin
                    if (!r_lock_s) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_rst_out   <= 1'b1;
                        r_locked_ok <= 1'b0;
                    end else begin
                        r_rst_out   <= 1'b0;
                        r_locked_ok <= 1'b1;
                        if (w_gate_last) begin
                            r_freq_cnt   <= w_edge_total;
                            r_freq_valid <= 1'b1;
                            r_gate_cnt   <= '0;
                            r_edge_cnt   <= '0;
                            if (!w_in_range) begin
                                r_state     <= ST_FAULT;
                                r_rst_out   <= 1'b1;
                                r_locked_ok <= 1'b0;
                                r_fault     <= 1'b1;
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
                                r_pll_reset <= 1'b1;
                                r_aux_cnt   <= '0;
`endif
                            end
                        end else begin
                            r_gate_cnt <= r_gate_cnt + CNT_W'(1);
                            r_edge_cnt <= w_edge_total;
                        end
                    end
                end

                ST_FAULT: begin
                    r_rst_out   <= 1'b1;
                    r_locked_ok <= 1'b0;
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
                    // Fixed-length PLL reset pulse; lock loss does not cut it short.
                    if (r_aux_cnt == AUX_W'(PLLRST_CYC - 1)) begin
                        r_pll_reset <= 1'b0;
                        r_state     <= ST_WAIT_LOCK;
                    end else begin
                        r_aux_cnt <= r_aux_cnt + AUX_W'(1);
                    end
`else
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_fault <= 1'b0;
                    end
`endif
                end

                default: begin
                    r_state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign rst_out    = r_rst_out;
    assign locked_ok  = r_locked_ok;
    assign fault      = r_fault;
    assign freq_cnt   = r_freq_cnt;
    assign freq_valid = r_freq_valid;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Testbench for pll_clk_monitor: directed scenarios with a scoreboard of
// expected measurement windows checked by an independent monitor process.
`timescale 1ns/1ps
module tb_pll_clk_monitor;
    localparam int CNT_W = 16;
    localparam int K_QUAL  = 0;   // window that qualifies entry into RUN
    localparam int K_RUN   = 1;   // in-range window while already in RUN
    localparam int K_FAULT = 2;   // out-of-range window

    // 27 MHz reference approximated with a 37 ns period.
    localparam real CLK_HALF = 18.5;
    localparam real HALF6 = CLK_HALF * 27.0 / 6.0;
    localparam real HALF5 = CLK_HALF * 27.0 / 5.0;
    localparam real HALF7 = CLK_HALF * 27.0 / 7.0;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_lock;
    logic             pll_clk_in;
    logic             rst_out;
    logic             locked_ok;
    logic             fault;
    logic [CNT_W-1:0] freq_cnt;
    logic             freq_valid;
    logic             pll_reset;

    real pclk_half = 0.0;
    int  total = 0;
    int  bad = 0;
    int  n_valid = 0;
    int  n_pulses = 0;
    int  last_len = 0;
    int  run_len = 0;

    typedef struct {
        int lo;
        int hi;
        int kind;
    } exp_t;
    exp_t sb[$];

    pll_clk_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .pll_clk_in (pll_clk_in),
        .rst_out    (rst_out),
        .locked_ok  (locked_ok),
        .fault      (fault),
        .freq_cnt   (freq_cnt),
        .freq_valid (freq_valid),
        .pll_reset  (pll_reset)
    );

    always #(CLK_HALF) clk = ~clk;

    // Measured PLL clock, phase-offset so its edges never coincide with clk.
    initial begin
        pll_clk_in = 1'b0;
        #3.1;
        forever begin
            if (pclk_half == 0.0) begin
                pll_clk_in = 1'b0;
                #10;
            end else begin
                #(pclk_half) pll_clk_in = ~pll_clk_in;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
        total++;
        if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d in %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int bound, input string name);
        int start;
        int k;
        start = n_valid;
        k = 0;
        while (n_valid == start && k < bound) begin
            @(posedge clk);
            k++;
        end
        #1;
        total++;
        if (n_valid == start) begin
            bad++;
            $display("FAIL %s: no freq_valid within %0d cycles, want one", name, bound);
        end
    endtask

    // Cycles from now until rst_out is seen low.
    task automatic measure_fall(input string name, input int lo, input int hi);
        int n;
        n = 0;
        while (rst_out !== 1'b0 && n < 6000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check_rng(name, n, lo, hi);
    endtask

    task automatic wait_pulse(input int target, input string name);
        int k;
        k = 0;
        while (n_pulses < target && k < 300) begin
            step(1);
            k++;
        end
        check(name, last_len, 64);
    endtask

    // Scoreboard monitor: every freq_valid pops one expected window.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (freq_valid === 1'b1) begin
                n_valid++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: freq_cnt=%0d, want no window", freq_cnt);
                end else begin
                    e = sb.pop_front();
                    check_rng("window_count", freq_cnt, e.lo, e.hi);
                    if (e.kind == K_QUAL) check("qual_rst_out_at_valid", rst_out, 1);
                    if (e.kind == K_RUN)  check("run_rst_out_at_valid", rst_out, 0);
                    @(negedge clk);
                    if (e.kind == K_FAULT) begin
                        check("fault_after_valid", fault, 1);
                        check("fault_rst_out", rst_out, 1);
                        check("fault_locked_ok", locked_ok, 0);
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
                        check("fault_pll_reset", pll_reset, 1);
`endif
                    end else begin
                        check("run_rst_out_next", rst_out, 0);
                        check("run_locked_ok_next", locked_ok, 1);
                        check("run_fault_next", fault, 0);
                    end
                end
            end
        end
    end

    // Width of each pll_reset pulse in clk cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (pll_reset === 1'b1) begin
                run_len++;
            end else if (run_len != 0) begin
                last_len = run_len;
                n_pulses++;
                run_len = 0;
            end
        end
    end

    initial begin
        #(CLK_HALF * 2.0 * 90000.0);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;
        int v0;
        rst = 1'b1;
        pll_lock = 1'b0;
        step(3);
        check("reset_rst_out", rst_out, 1);
        check("reset_locked_ok", locked_ok, 0);
        check("reset_fault", fault, 0);
        check("reset_freq_cnt", freq_cnt, 0);
        check("reset_freq_valid", freq_valid, 0);
        check("reset_pll_reset", pll_reset, 0);
        rst = 1'b0;
        step(5);
        check("wait_lock_rst_out", rst_out, 1);

        // 6 MHz lock-up and qualification.
        pclk_half = HALF6;
        step(20);
        sb.push_back('{599, 601, K_QUAL});
        pll_lock = 1'b1;
        measure_fall("qualify_latency", 3726, 3728);
        check("run_locked_ok", locked_ok, 1);
        check("run_fault", fault, 0);
        sb.push_back('{599, 601, K_RUN});
        wait_valid(2800, "run_window");

        // Lock loss in RUN: rst_out within 3 cycles, then requalify.
        pll_lock = 1'b0;
        n = 0;
        while (rst_out !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        check_rng("lockloss_latency", n, 1, 3);
        check("lockloss_locked_ok", locked_ok, 0);
        step(10 - n);
        sb.push_back('{599, 601, K_QUAL});
        pll_lock = 1'b1;
        measure_fall("requalify_latency", 3726, 3728);

        // Switch to 7 MHz in RUN.
        sb.push_back('{599, 601, K_RUN});
        wait_valid(2800, "pre_switch_window");
        pclk_half = HALF7;
        sb.push_back('{695, 705, K_FAULT});
        wait_valid(2800, "fast_window");
        check("fast_fault", fault, 1);
        check("fast_rst_out", rst_out, 1);
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
        pclk_half = HALF6;
        wait_pulse(1, "auto_pulse_len_fast");
        check("auto_fault_held", fault, 1);
        sb.push_back('{599, 601, K_QUAL});
        wait_valid(4000, "auto_recover_fast");
`else
        step(3000);
        check("fault_hold", fault, 1);
        check("fault_hold_rst_out", rst_out, 1);
        check_rng("fault_freq_cnt_held", freq_cnt, 695, 705);
        pll_lock = 1'b0;
        step(4);
        check("fault_exit_on_lockloss", fault, 0);
        check("fault_exit_rst_out", rst_out, 1);
        pclk_half = HALF6;
        step(10);
        sb.push_back('{599, 601, K_QUAL});
        pll_lock = 1'b1;
        measure_fall("requalify_after_fault", 3726, 3728);
`endif

        // Asynchronous reset in RUN, checked before any clock edge.
        step(50);
        rst = 1'b1;
        #2;
        check("async_rst_out", rst_out, 1);
        check("async_locked_ok", locked_ok, 0);
        check("async_freq_cnt", freq_cnt, 0);
        pll_lock = 1'b0;
        step(3);
        rst = 1'b0;
        step(5);

        // 5 MHz: slow input faults.
        pclk_half = HALF5;
        step(20);
        sb.push_back('{495, 505, K_FAULT});
        pll_lock = 1'b1;
        wait_valid(4000, "slow_window");
`ifdef PLL_CLK_MONITOR_AUTO_RESET_EN
        pclk_half = HALF6;
        wait_pulse(2, "auto_pulse_len_slow");
        sb.push_back('{599, 601, K_QUAL});
        wait_valid(4000, "auto_recover_slow");
        step(2);
        check("auto_recover_locked_ok", locked_ok, 1);
        check("auto_recover_fault", fault, 0);
`else
        step(100);
        check("slow_fault", fault, 1);
        check("slow_rst_out", rst_out, 1);
`endif
        pll_lock = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(5);

        // Lock toggling faster than the settle time never measures.
        pclk_half = HALF6;
        viol = 0;
        v0 = n_valid;
        for (int t = 0; t < 8; t++) begin
            pll_lock = ~pll_lock;
            for (int c = 0; c < 500; c++) begin
                step(1);
                if (rst_out !== 1'b1) viol++;
            end
        end
        pll_lock = 1'b0;
        check("toggle_rst_out_low_cycles", viol, 0);
        check("toggle_valid_count", n_valid - v0, 0);

        step(10);
        check("scoreboard_left", sb.size(), 0);
`ifndef PLL_CLK_MONITOR_AUTO_RESET_EN
        check("pll_reset_pulses", n_pulses, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_clk_monitor.md
Name: pll_clk_monitor

Overview:
- Consumer side of a PLL output pair (clock plus lock). Runs in the 27 MHz reference domain.
- Qualifies the PLL's lock, measures the PLL output frequency over a fixed gate window, and releases a downstream reset only when lock is stable and the frequency is in range.
- Sits between a Gowin rPLL instance (e.g. the 6 MHz camera clock) and the logic that consumes that clock.

Parameters:
- SETTLE_CYC, 1024, clk cycles lock must stay high before measurement starts.
- GATE_CYC, 2700, clk cycles per measurement window (100 us at 27 MHz).
- EXP_MIN, 590, minimum accepted edge count per window, inclusive.
- EXP_MAX, 610, maximum accepted edge count per window, inclusive.
- CNT_W, 16, width of the edge and gate counters.
- PLLRST_CYC, 64, cycles of pll_reset pulse; used only with the optional feature.

Ports:
- clk  in  1  27 MHz reference clock.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  PLL lock; asynchronous to clk.
- pll_clk_in  in  1  measured PLL clock; asynchronous; frequency must be < clk/2.
- rst_out  out  1  active-high reset to downstream logic; asserts asynchronously with rst, deasserts synchronously to clk.
- locked_ok  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- freq_cnt  out  CNT_W  edge count of the last completed window.
- freq_valid  out  1  one-cycle pulse when freq_cnt updates.
- pll_reset  out  1  reset request to the PLL; constant 0 without the optional feature.

Behaviour:
- Reset values: rst_out=1, locked_ok=0, fault=0, freq_cnt=0, freq_valid=0, pll_reset=0, state=WAIT_LOCK.
- Synchronisation:
  - pll_lock passes through a 2-FF synchroniser to give lock_s.
  - pll_clk_in passes through a 2-FF synchroniser plus a third FF. A rising edge is counted when sync2=1 and ff3=0.
- Edge counter:
  - Saturates at all-ones.
  - Cleared on the cycle after each window closes.
  - An edge detected on the last gate cycle belongs to the closing window.
- Gate counter: counts 0..GATE_CYC-1. The window closes on cycle GATE_CYC-1.
- State WAIT_LOCK: rst_out=1. On lock_s=1, go to SETTLE with the settle counter at 0.
- State SETTLE:
  - rst_out=1.
  - lock_s=0 returns to WAIT_LOCK and clears the settle counter.
  - On count SETTLE_CYC-1, go to MEASURE with the gate and edge counters at 0.
- State MEASURE: rst_out=1. At window close:
  - Latch freq_cnt and pulse freq_valid on the next cycle.
  - EXP_MIN<=count<=EXP_MAX goes to RUN; otherwise go to FAULT.
- State RUN:
  - rst_out=0 and locked_ok=1 from the first RUN cycle. That is one cycle after the freq_valid that qualified it.
  - Measurement repeats back-to-back, and every window produces freq_valid.
  - An out-of-range count goes to FAULT on the cycle after window close.
- State FAULT:
  - rst_out=1, fault=1.
  - freq_cnt holds the failing value.
  - Without the macro, FAULT exits only on rst or on lock_s=0 (to WAIT_LOCK).
- Lock loss:
  - lock_s=0 in any state except WAIT_LOCK goes to WAIT_LOCK on the next cycle.
  - rst_out is 1 no later than 3 clk cycles after pll_lock falls.
  - Lock loss takes priority over a simultaneous window close; freq_valid is not pulsed in that case.
- rst mid-operation: all outputs return to reset values immediately (asynchronously); counters clear.

Optional Feature:
- Macro: PLL_CLK_MONITOR_AUTO_RESET_EN.
- When defined:
  - On entry to FAULT, pll_reset=1 for exactly PLLRST_CYC cycles, then 0, and the state goes to WAIT_LOCK.
  - fault stays 1 until the next RUN entry.
  - Lock loss during the pulse does not shorten it.
- When undefined: pll_reset is tied to 0 and FAULT behaves as described above.

Test Plan:
- Reset, then pll_lock=1 with pll_clk_in at 6 MHz:
  - freq_valid pulses with freq_cnt in 599..601.
  - rst_out falls 1 cycle later, 2+1024+2700+1 (±1) cycles after lock rises.
  - locked_ok=1.
- In RUN, drop pll_lock for 10 cycles -> rst_out=1 within 3 cycles, state re-qualifies, and rst_out falls again after another settle plus gate window.
- pll_clk_in at 5 MHz (~500 edges) -> freq_valid, freq_cnt≈500, fault=1, rst_out stays 1.
- In RUN, switch pll_clk_in to 7 MHz mid-window -> the next full window is ~700, giving FAULT one cycle after window close.
- pll_lock toggling every 500 cycles (shorter than SETTLE_CYC) -> never leaves WAIT_LOCK/SETTLE, rst_out constantly 1, no freq_valid.
- With PLL_CLK_MONITOR_AUTO_RESET_EN, a 5 MHz input -> pll_reset high for exactly 64 cycles, then WAIT_LOCK. Restoring 6 MHz gives RUN and fault=0.
